// File: rtl/bit_serializer.sv
// bit_serializer: parallel-in, serial-out feeder for the bit-stream detectors.
// A one-word hold register behind the shifter lets words stream back to back
// with no idle cycle between the last bit of one word and the first of the next.
module bit_serializer #(
   parameter int DATA_W    = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              ser_out,
   output logic              ser_valid,
   output logic              frame_start,
   output logic              word_done,
   output logic              busy
);

   localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t            state, state_n;
   logic [DATA_W-1:0] sh, hold;
   logic [CW-1:0]     cnt;
   logic              hold_full;
   logic              accept, last, frees, load_hold, load_in, to_hold;

   // The hold register being full is the only thing that back-pressures the source.
   assign in_ready = !hold_full && !reset;

   // Next state and datapath steering: the shifter frees when idle or on its last bit.
   always_comb begin
      state_n   = state;
      accept    = in_valid && in_ready;
      last      = (state == SHIFT) && (cnt == LAST);
      frees     = (state == IDLE) || last;
      load_hold = frees && hold_full;
      load_in   = frees && !hold_full && accept;
      to_hold   = !frees && accept;
      if (frees)
         state_n = (load_hold || load_in) ? SHIFT : IDLE;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   // Shifter, bit counter and hold register; reset discards any in-flight word.
   always_ff @(posedge clk) begin
      if (reset) begin
         sh        <= '0;
         cnt       <= '0;
         hold      <= '0;
         hold_full <= 1'b0;
      end else begin
         if (load_hold) begin
            sh        <= hold;
            cnt       <= '0;
            hold_full <= 1'b0;
         end else if (load_in) begin
            sh  <= in_data;
            cnt <= '0;
         end else if (state == SHIFT) begin
            sh  <= MSB_FIRST ? {sh[DATA_W-2:0], 1'b0} : {1'b0, sh[DATA_W-1:1]};
            cnt <= last ? '0 : cnt + 1'b1;
         end
         if (to_hold) begin
            hold      <= in_data;
            hold_full <= 1'b1;
         end
      end
   end

   // Serial outputs decode directly from flops; data is forced to 0 while idle.
   always_comb begin
      ser_valid   = (state == SHIFT);
      ser_out     = ser_valid && (MSB_FIRST ? sh[DATA_W-1] : sh[0]);
      frame_start = ser_valid && (cnt == '0);
      word_done   = last;
      busy        = ser_valid || hold_full;
   end

endmodule
